hazard_scoreboard: RTL

Parametrised register-dependency scoreboard for the Nux processor pipeline. It generalises the fixed per-register tracker with these additions:
- configurable register count, read ports and write ports;
- per-write-port result latency and a bypass distance;
- write-after-write ordering checks, a pipeline flush and a saturating stall-cycle counter.

It sits between decode and issue and drives the single hold signal consumed by fetch and decode.

---
 rtl/hazard_scoreboard_if.sv | 29 ++
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bus between decode and the hazard scoreboard.
// Decode (master) presents one instruction's read and write ports plus a flush.
// The scoreboard (slave) answers with a combinational hold and issue acknowledge.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                       issue_valid;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD-1:0][AW-1:0]  rd_addr;
    logic [NUM_WR-1:0]          wr_en;
    logic [NUM_WR-1:0][AW-1:0]  wr_addr;
    logic                       flush;
    logic                       hold;
    logic                       issue_ack;

    modport master (
        output issue_valid, rd_en, rd_addr, wr_en, wr_addr, flush,
        input  hold, issue_ack
    );

    modport slave (
        input  issue_valid, rd_en, rd_addr, wr_en, wr_addr, flush,
        output hold, issue_ack
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard sitting between decode and issue.
// Each tracked register owns a 4-bit down-counter holding the number of cycles
// until its pending write becomes visible. Reads stall while the counter is
// beyond the bypass distance; writes stall while an older write to the same
// register would still finish after them. A flush clears every pending write.
module hazard_scoreboard #(
    parameter int          NUM_REGS         = 32,
    parameter int          NUM_RD           = 3,
    parameter int          NUM_WR           = 2,
    parameter int unsigned WR_LAT [NUM_WR]  = '{3, 4},
    parameter int          FWD_DIST         = 1,
    parameter int          CNT_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_scoreboard_if.slave    bus,
    output logic [NUM_REGS-1:0]   busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    // A bypass distance of 15 or more can never be exceeded by a 4-bit counter,
    // so clamping keeps the compare 4 bits wide without changing behaviour.
    localparam logic [3:0] FWD_C = (FWD_DIST >= 15) ? 4'd15 :
                                   (FWD_DIST <= 0)  ? 4'd0  : 4'(FWD_DIST);

    logic [3:0]          cnt     [NUM_REGS];
    logic [3:0]          cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic                rd_hazard;
    logic                waw_hazard;
    logic                hold_int;
    logic                ack_int;

    // Hazard detection against the counters as they stand this cycle, so a
    // read and a write of the same register in one instruction see the old value.
    always_comb begin
        rd_hazard  = 1'b0;
        waw_hazard = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.rd_en[k] && (int'(bus.rd_addr[k]) < NUM_REGS)) begin
                if (cnt[bus.rd_addr[k]] > FWD_C) begin
                    rd_hazard = 1'b1;
                end
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k] && (int'(bus.wr_addr[k]) < NUM_REGS)) begin
                if (cnt[bus.wr_addr[k]] > 4'(WR_LAT[k])) begin
                    waw_hazard = 1'b1;
                end
            end
        end
    end

    // Hold and acknowledge are purely combinational; a flush masks both.
    always_comb begin
        hold_int = bus.issue_valid && !bus.flush && (rd_hazard || waw_hazard);
        ack_int  = bus.issue_valid && !bus.flush && !hold_int;
    end

    assign bus.hold      = hold_int;
    assign bus.issue_ack = ack_int;

    // Next counter values: flush clears, an accepted write loads its latency
    // (largest wins when ports collide), otherwise pending counters drain.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt[r] != 4'd0) ? (cnt[r] - 4'd1) : 4'd0;
        end
        if (bus.flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_nxt[r] = 4'd0;
            end
        end else if (ack_int) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k] && (int'(bus.wr_addr[k]) < NUM_REGS)) begin
                    if (!wr_hit[bus.wr_addr[k]] ||
                        (4'(WR_LAT[k]) > cnt_nxt[bus.wr_addr[k]])) begin
                        cnt_nxt[bus.wr_addr[k]] = 4'(WR_LAT[k]);
                    end
                    wr_hit[bus.wr_addr[k]] = 1'b1;
                end
            end
        end
    end

    // Counter state; draining continues even while decode is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= 4'd0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Busy flags are a direct view of the registered counters.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != 4'd0);
        end
    end

    // Saturating count of held cycles, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (hold_int && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
